// File: rtl/div_stage_pkg.sv
// Shared types and constants for the registered array-divider stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   NW_DEF / DW_DEF : default dividend / divisor widths (dividend is 2x divisor)
//   DZ_QUOT         : quotient reported on divide-by-zero (all ones)
//   div_result_t    : one result FIFO entry {q, r, dz, ovf}
package div_stage_pkg;

    localparam int NW_DEF = 16;
    localparam int DW_DEF = 8;

    localparam logic [DW_DEF-1:0] DZ_QUOT = '1;

    typedef struct packed {
        logic [DW_DEF-1:0] q;
        logic [DW_DEF-1:0] r;
        logic              dz;
        logic              ovf;
    } div_result_t;

endpackage

// File: rtl/div_result_fifo.sv
// Circular result FIFO holding div_result_t entries between the divider and the consumer.
// Latency: push at edge k is visible at the head (empty deasserts) right after edge k.
// Backpressure: push while full is accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_dat  : write request and payload
//   pop             : remove the head entry (ignored while empty)
//   head_dat        : current head entry
//   full, empty     : occupancy status
module div_result_fifo
    import div_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  div_result_t push_dat,
    input  logic        pop,
    output div_result_t head_dat,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    div_result_t  mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves in the same cycle;
    // the write slot is the one being vacated, so count stays unchanged.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // Storage is cleared so the head reads all-zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_array_stage.sv
// Registered operand/result wrapper around an external combinational 16/8 array divider.
// Latency: request accepted at edge k gives out_valid after edge k+1 (FIFO empty).
// Backpressure: with out_ready low, holds DEPTH results plus one operand, then drops in_ready.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready/in_n/in_d: request stream (dividend, divisor)
//   div_n/div_d                : registered operands driving the array
//   div_q/div_r                : array quotient/remainder (combinational from div_n/div_d)
//   out_valid/out_ready        : result stream handshake
//   out_q/out_r/out_dz/out_ovf : quotient, remainder, divide-by-zero, quotient overflow
//   busy                       : operand register or result FIFO holds data
module div_array_stage
    import div_stage_pkg::*;
#(
    parameter int NW    = NW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] in_n,
    input  logic [DW-1:0] in_d,
    output logic [NW-1:0] div_n,
    output logic [DW-1:0] div_d,
    input  logic [DW-1:0] div_q,
    input  logic [DW-1:0] div_r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_q,
    output logic [DW-1:0] out_r,
    output logic          out_dz,
    output logic          out_ovf,
    output logic          busy
);

    // Operand register (S1)
    logic          s1_valid;
    logic [NW-1:0] s1_n;
    logic [DW-1:0] s1_d;

    logic          accept;
    logic          s1_retire;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    div_result_t   push_res;
    div_result_t   head_res;

    // Handshake
    assign fifo_pop  = !fifo_empty && out_ready;
    // S1 may drain into a full FIFO when the head pops in the same cycle,
    // which is what keeps one request per cycle flowing under out_ready=1.
    assign s1_retire = s1_valid && (!fifo_full || fifo_pop);
    // Depends only on stage state and out_ready, never on in_valid.
    assign in_ready  = !s1_valid || s1_retire;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_n     <= '0;
            s1_d     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_n     <= in_n;
                s1_d     <= in_d;
            end else if (s1_retire) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // The array sees the operand registers directly; its outputs are sampled
    // into the FIFO at the retire edge, giving it a full cycle to settle.
    assign div_n = s1_n;
    assign div_d = s1_d;

    // Flag logic and forcing. On divide-by-zero the array result is
    // meaningless, so a fixed pattern is substituted. Approximate array
    // variants are passed through uncorrected; only the flags are exact.
    always_comb begin
        push_res = '0;
        if (s1_d == '0) begin
            push_res.q   = DZ_QUOT;
            push_res.r   = s1_n[DW-1:0];
            push_res.dz  = 1'b1;
            push_res.ovf = 1'b0;
        end else begin
            push_res.q   = div_q;
            push_res.r   = div_r;
            push_res.dz  = 1'b0;
            // Quotient fits in DW bits only when the upper dividend half is below d.
            push_res.ovf = (s1_n[NW-1:DW] >= s1_d);
        end
    end

    div_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (s1_retire),
        .push_dat (push_res),
        .pop      (fifo_pop),
        .head_dat (head_res),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Output stream straight from the FIFO head; it only advances on a pop,
    // so fields hold steady while stalled.
    assign out_valid = !fifo_empty;
    assign out_q     = head_res.q;
    assign out_r     = head_res.r;
    assign out_dz    = head_res.dz;
    assign out_ovf   = head_res.ovf;

    assign busy = s1_valid || !fifo_empty;

endmodule
